// File: rtl/seg7_time_display.sv
// Multiplexes the MM.SS BCD digits onto a 4-digit common-anode display, with a blinking colon.
// Outputs are registered, 1 cycle behind ctr/idx; there is no handshake and no backpressure.
module seg7_time_display #(
  parameter int REFRESH_DIV        = 100_000,
  parameter int BLANK_CYCLES       = 16,
  parameter bit LEADING_ZERO_BLANK = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic [3:0] sec_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] min_10s,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] ctr;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          tick_q;
  logic          in_blank;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (32'(ctr) < 32'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    digit = snap[3:0];
    case (idx)
      2'd0: digit = snap[3:0];
      2'd1: digit = snap[7:4];
      2'd2: digit = snap[11:8];
      2'd3: digit = snap[15:12];
      default: digit = snap[3:0];
    endcase
    // Leading minute zero is suppressed rather than drawn.
    if (LEADING_ZERO_BLANK && (idx == 2'd3) && (digit == 4'd0))
      digit_seg = 7'h7F;
    else
      digit_seg = decode(digit);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ctr    <= '0;
      idx    <= 2'd0;
      snap   <= 16'h0000;
      tick_q <= 1'b0;
      an     <= 4'b1111;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      tick_q <= tick_1Hz;
      if (ctr == CTR_LAST) begin
        ctr <= '0;
        idx <= idx + 2'd1;
        // Frame wrap: latch all digits together so a frame never shows a mixed time.
        if (idx == 2'd3)
          snap <= {min_10s, min_1s, sec_10s, sec_1s};
      end else begin
        ctr <= ctr + CW'(1);
      end
      an  <= in_blank ? 4'b1111 : ~(4'b0001 << idx);
      seg <= digit_seg;
      dp  <= ~(!in_blank && (idx == 2'd2) && tick_q);
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Directed bench for seg7_time_display with REFRESH_DIV=8, BLANK_CYCLES=2, LEADING_ZERO_BLANK=1.
module tb_seg7_time_display;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1Hz = 1'b0;
  logic [3:0] sec_1s, sec_10s, min_1s, min_10s;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  seg7_time_display #(
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2),
    .LEADING_ZERO_BLANK(1'b1)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .tick_1Hz(tick_1Hz),
    .sec_1s(sec_1s),
    .sec_10s(sec_10s),
    .min_1s(min_1s),
    .min_10s(min_10s),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic step();
    @(posedge clk_100MHz);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) step();
  endtask

  task automatic set_time(input logic [15:0] t);
    {min_10s, min_1s, sec_10s, sec_1s} = t;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Checks every cycle of frame f; loads the next time/tick at the start of slot 3.
  task automatic check_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic tk,
                             input logic [15:0] next_t, input logic next_tk);
    logic [6:0] e;
    logic [3:0] ea;
    int zeros;
    zeros = 0;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: e = s0;
        1: e = s1;
        2: e = s2;
        default: e = s3;
      endcase
      for (int c = 0; c < 8; c++) begin
        run_to(1 + 32 * f + 8 * s + c);
        ea = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
        chk($sformatf("f%0d_s%0d_c%0d_an", f, s, c), 32'(an), 32'(ea));
        chk($sformatf("f%0d_s%0d_c%0d_seg", f, s, c), 32'(seg), 32'(e));
        chk($sformatf("f%0d_s%0d_c%0d_dp", f, s, c), 32'(dp),
            32'(!(tk && s == 2 && c >= 2)));
        if (dp === 1'b0) zeros++;
        if (s == 3 && c == 0) begin
          set_time(next_t);
          tick_1Hz = next_tk;
        end
      end
    end
    chk($sformatf("f%0d_dp_low_count", f), 32'(zeros), tk ? 32'd6 : 32'd0);
  endtask

  initial begin
    set_time(16'h5959);
    reset = 1'b1;
    step();
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'd1);
    step();
    step();
    reset = 1'b0;
    edge_n = 0;

    // Before the first wrap snap is zero, whatever the inputs are.
    check_frame(0, 7'h40, 7'h40, 7'h40, 7'h7F, 1'b0, 16'h1234, 1'b0);
    check_frame(1, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 16'h050A, 1'b1);
    check_frame(2, 7'h3F, 7'h40, 7'h12, 7'h7F, 1'b1, 16'h1233, 1'b1);

    // One cycle after the wrap: sec_1s change must wait a whole frame.
    sec_1s = 4'd7;
    for (int c = 0; c < 8; c++) begin
      run_to(97 + c);
      chk($sformatf("snap_hold_c%0d_seg", c), 32'(seg), 32'h30);
    end

    run_to(115);
    chk("tick_pre_dp", 32'(dp), 32'd0);
    tick_1Hz = 1'b0;
    step();
    chk("tick_fall_e1_dp", 32'(dp), 32'd0);
    step();
    chk("tick_fall_e2_dp", 32'(dp), 32'd1);
    tick_1Hz = 1'b1;
    step();
    chk("tick_rise_e1_dp", 32'(dp), 32'd1);
    step();
    chk("tick_rise_e2_dp", 32'(dp), 32'd0);

    run_to(121);
    chk("f3_s3_seg", 32'(seg), 32'h79);
    // Changed in the wrap cycle itself: captured.
    run_to(127);
    min_1s = 4'd9;
    run_to(128);
    check_frame(4, 7'h78, 7'h30, 7'h10, 7'h79, 1'b1, 16'h1937, 1'b1);

    run_to(180);
    chk("pre_rst_an", 32'(an), 32'hB);
    chk("pre_rst_dp", 32'(dp), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    step();
    step();
    reset = 1'b0;
    edge_n = 0;
    step();
    chk("rel_e1_an", 32'(an), 32'hF);
    chk("rel_e1_seg", 32'(seg), 32'h40);
    step();
    chk("rel_e2_an", 32'(an), 32'hF);
    step();
    chk("rel_e3_an", 32'(an), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_time_display.md
# seg7_time_display

Downstream display stage for the binary clock on the 100 MHz board. Takes the seconds/minutes BCD digits and the 1 Hz tick, and time-multiplexes them onto a 4-digit common-anode seven-segment display. The display shows MM.SS, with the digit-2 decimal point blinking as a colon. It adds per-slot anode blanking against ghosting, and a frame-start snapshot so no digit changes partway through a frame.

## Interface
Parameters:
- REFRESH_DIV, 100_000, clock cycles per digit slot (1 kHz slot rate, 250 Hz frame); legal range ≥ BLANK_CYCLES+1 and ≥ 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range ≥ 0.
- LEADING_ZERO_BLANK, 1, when 1, min_10s == 0 shows as blank.

Ports:
- clk_100MHz  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- tick_1Hz  in  1  1 Hz square wave from the binary clock.
- sec_1s, sec_10s, min_1s, min_10s  in  4 each  BCD digits.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low; an[0] = rightmost digit.

## Operation
- Slot map:
  - idx 0: snap sec_1s.
  - idx 1: snap sec_10s.
  - idx 2: snap min_1s, plus the colon dp.
  - idx 3: snap min_10s.
- Internal state:
  - ctr, width $clog2(REFRESH_DIV).
  - idx, 2 bits.
  - snap, 16 bits.
  - tick_q, 1 bit.
- ctr counts 0 → REFRESH_DIV-1.
- At ctr == REFRESH_DIV-1:
  - ctr goes to 0.
  - idx goes to idx+1 mod 4.
  - If idx == 3 (frame wrap), snap loads all four input digits in the same cycle.
- tick_q registers tick_1Hz every cycle.
- Slot phases: BLANK while ctr < BLANK_CYCLES, DRIVE otherwise.
- Registered outputs, updated every cycle from the current ctr, idx, snap and tick_q:
  - an: 4'b1111 in BLANK; in DRIVE, all ones except bit idx = 0.
  - seg: decode(snap digit[idx]), in both phases.
  - dp: 0 only when DRIVE, idx == 2 and tick_q == 1; otherwise 1.
- Decode table:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19.
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Any value 10–15 shows a dash, 0x3F.
  - Blank is 0x7F, used for idx 3 when LEADING_ZERO_BLANK = 1 and the snapped min_10s == 0.
- Input values that change mid-frame are not shown until the next frame wrap.

## Timing
- Reset values, registered on the first edge with reset = 1:
  - an = 4'b1111, seg = 0x7F, dp = 1.
  - ctr = 0, idx = 0, snap = 0, tick_q = 0.
- Reset asserted mid-slot: all outputs return to these values on the next edge, regardless of phase.
- Latency:
  - Outputs lag the internal ctr/idx by exactly 1 cycle.
  - tick_1Hz reaches dp in 2 cycles: tick_q, then the output register.
- After reset deasserts, the 1st edge outputs slot 0 in BLANK. an first equals 4'b1110 on edge BLANK_CYCLES+1.
- Every slot lasts exactly REFRESH_DIV cycles, and a frame lasts 4·REFRESH_DIV cycles.
- BLANK_CYCLES = 0: no blank phase; anodes switch directly.
- Between reset release and the first frame wrap, snap = 0, so digits 0–2 show 0x40 and digit 3 follows LEADING_ZERO_BLANK.
- An input change in the same cycle as the wrap is captured.
- An input change 1 cycle after the wrap waits a full frame.
- No handshake; the inputs are treated as stable levels from the same clock domain.

## Test plan
Settings for all cases: REFRESH_DIV=8, BLANK_CYCLES=2, LEADING_ZERO_BLANK=1.
- **Reset:** hold reset 3 cycles, mid-operation while in slot 2 DRIVE → next edge an=1111, seg=0x7F, dp=1. After release, an=1110 first appears on the 3rd edge.
- **Digit display:** min=12, sec=34, wait one wrap → slots in order:
  - 0x19 with an=1110.
  - 0x30 with an=1101.
  - 0x24 with an=1011.
  - 0x79 with an=0111.
  - Each slot drives its anode for 6 of 8 cycles and has an=1111 for 2 cycles.
- **Leading zero and invalid BCD:** min=05, sec_10s=0, sec_1s=4'hA → slot 3 seg=0x7F, slot 2 seg=0x12, slot 1 seg=0x40, slot 0 seg=0x3F.
- **Snapshot:** change sec_1s from 3 to 7 during slot 1 → the current frame keeps 0x30; slot 0 of the next frame shows 0x78.
- **Colon:**
  - tick_1Hz=1 → dp=0 only during slot 2 DRIVE cycles, 6 per frame.
  - tick_1Hz=0 → dp=1 throughout.
  - Toggling tick changes dp 2 cycles later.
